switch_debouncer: RTL

Front-end conditioning stage for the board slide switches. It synchronizes the raw asynchronous switch inputs, debounces each bit independently, and produces a clean 4-bit level vector. That vector feeds the seven-segment priority decoder's switch input directly. One-cycle rise and fall event pulses are also produced for downstream sequential logic.

---
 rtl/switch_debouncer.sv | 58 +++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Slide-switch front end: two-flop synchronizer, independent per-bit debounce
// counters, registered clean level plus one-cycle rise/fall event pulses.
module switch_debouncer #(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // A counter only runs while the synchronized input disagrees with the
  // accepted level; any cycle of agreement throws the partial count away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch  <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == switch[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          switch[i]  <= s2[i];
          sw_rise[i] <= s2[i];
          sw_fall[i] <= ~s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
